// File: rtl/orb_pingpong_buffer_if.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// orb_pingpong_buffer_if
// Bus bundle between the frame writer/reader clients and the ping-pong
// frame store.
//   master : client side (drives write, read and swap requests)
//   slave  : buffer side (returns read data, bank select, status counters)
// Signals:
//   wr_en/wr_addr/wr_data/wr_done : writer port into the inactive bank
//   rd_en/rd_addr/rd_data/rd_valid: reader port from the active bank
//   swap                          : reader frame-boundary pulse
//   bank_rd/frame_ready           : bank state
//   underrun_cnt/drop_cnt         : saturating status counters
// ---------------------------------------------------------------------------
interface orb_pingpong_buffer_if #(
   parameter int DATA_W = 12,
   parameter int ADDR_W = 11,
   parameter int CNT_W  = 8
);
   logic              wr_en;
   logic [ADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0] wr_data;
   logic              wr_done;
   logic              rd_en;
   logic [ADDR_W-1:0] rd_addr;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid;
   logic              swap;
   logic              bank_rd;
   logic              frame_ready;
   logic [CNT_W-1:0]  underrun_cnt;
   logic [CNT_W-1:0]  drop_cnt;

   modport master (
      output wr_en, wr_addr, wr_data, wr_done, rd_en, rd_addr, swap,
      input  rd_data, rd_valid, bank_rd, frame_ready, underrun_cnt, drop_cnt
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, wr_done, rd_en, rd_addr, swap,
      output rd_data, rd_valid, bank_rd, frame_ready, underrun_cnt, drop_cnt
   );
endinterface

// File: rtl/orb_pingpong_buffer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// orb_pingpong_buffer
// Double-buffered orbit frame store. The writer fills the inactive bank
// while the reader streams the active bank; banks swap at reader frame
// boundaries only when a complete frame is waiting (unless the legacy
// blind-swap mode is selected). Underruns and overwritten frames are
// counted in saturating counters.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : orb_pingpong_buffer_if.slave (write, read, swap and status)
// ---------------------------------------------------------------------------
module orb_pingpong_buffer #(
   parameter int DATA_W             = 12,
   parameter int ADDR_W             = 11,
   parameter int READ_AHEAD         = 1,
   parameter int REPEAT_ON_UNDERRUN = 1,
   parameter int CNT_W              = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   orb_pingpong_buffer_if.slave  bus
);

   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] RA_OFS = ADDR_W'(READ_AHEAD);
   localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0]  CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   typedef enum logic {RD0 = 1'b0, RD1 = 1'b1} state_e;

   state_e            state_q, state_d;
   logic              frame_ready_q, frame_ready_d;
   logic [CNT_W-1:0]  underrun_cnt_q, underrun_cnt_d;
   logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;
   logic [DATA_W-1:0] rd_data_q, rd_data_d;
   logic              rd_valid_q, rd_valid_d;
   logic [ADDR_W-1:0] rd_addr_eff;

   // Bank storage, intentionally not reset.
   logic [DATA_W-1:0] mem_b0 [DEPTH];
   logic [DATA_W-1:0] mem_b1 [DEPTH];

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      if (v == CNT_MAX) begin
         return v;
      end else begin
         return v + CNT_ONE;
      end
   endfunction

   function automatic state_e toggle(input state_e s);
      case (s)
         RD0:     return RD1;
         RD1:     return RD0;
         default: return RD0;
      endcase
   endfunction

   // Offset wraps naturally modulo the bank depth.
   assign rd_addr_eff = bus.rd_addr + RA_OFS;

   // Bank write port: always targets the bank not being read.
   always_ff @(posedge clk) begin
      if (!rst && bus.wr_en) begin
         if (state_q == RD1) begin
            mem_b0[bus.wr_addr] <= bus.wr_data;
         end else begin
            mem_b1[bus.wr_addr] <= bus.wr_data;
         end
      end
   end

   // Read port next value: hold unless a read is requested.
   always_comb begin
      rd_data_d  = rd_data_q;
      rd_valid_d = bus.rd_en;
      if (bus.rd_en) begin
         if (state_q == RD1) begin
            rd_data_d = mem_b1[rd_addr_eff];
         end else begin
            rd_data_d = mem_b0[rd_addr_eff];
         end
      end else begin
         rd_data_d = rd_data_q;
      end
   end

   // Bank state machine next-state and counter logic.
   always_comb begin
      state_d        = state_q;
      frame_ready_d  = frame_ready_q;
      underrun_cnt_d = underrun_cnt_q;
      drop_cnt_d     = drop_cnt_q;
      case ({bus.swap, bus.wr_done})
         2'b01: begin
            if (frame_ready_q) begin
               drop_cnt_d = sat_inc(drop_cnt_q);
            end else begin
               frame_ready_d = 1'b1;
            end
         end
         2'b10: begin
            if (frame_ready_q) begin
               state_d       = toggle(state_q);
               frame_ready_d = 1'b0;
            end else begin
               underrun_cnt_d = sat_inc(underrun_cnt_q);
               if (REPEAT_ON_UNDERRUN == 0) begin
                  state_d = toggle(state_q);
               end else begin
                  state_d = state_q;
               end
            end
         end
         2'b11: begin
            // A frame completing on the boundary is consumed immediately;
            // if one was already waiting it is lost.
            state_d       = toggle(state_q);
            frame_ready_d = 1'b0;
            if (frame_ready_q) begin
               drop_cnt_d = sat_inc(drop_cnt_q);
            end else begin
               drop_cnt_d = drop_cnt_q;
            end
         end
         default: begin
            state_d = state_q;
         end
      endcase
   end

   // State, status and read-port registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= RD0;
         frame_ready_q  <= 1'b0;
         underrun_cnt_q <= {CNT_W{1'b0}};
         drop_cnt_q     <= {CNT_W{1'b0}};
         rd_data_q      <= {DATA_W{1'b0}};
         rd_valid_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         frame_ready_q  <= frame_ready_d;
         underrun_cnt_q <= underrun_cnt_d;
         drop_cnt_q     <= drop_cnt_d;
         rd_data_q      <= rd_data_d;
         rd_valid_q     <= rd_valid_d;
      end
   end

   assign bus.rd_data      = rd_data_q;
   assign bus.rd_valid     = rd_valid_q;
   assign bus.bank_rd      = (state_q == RD1);
   assign bus.frame_ready  = frame_ready_q;
   assign bus.underrun_cnt = underrun_cnt_q;
   assign bus.drop_cnt     = drop_cnt_q;

endmodule

// File: tb/tb_orb_pingpong_buffer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_orb_pingpong_buffer
// Directed bench for the ping-pong frame store. Instance a uses
// repeat-on-underrun, instance b uses the legacy blind swap.
// ---------------------------------------------------------------------------
module tb_orb_pingpong_buffer;

   localparam int DATA_W = 12;
   localparam int ADDR_W = 11;
   localparam int CNT_W  = 8;

   logic clk;
   logic rst;
   int   n_cmp;
   int   n_err;

   orb_pingpong_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus_a ();
   orb_pingpong_buffer_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus_b ();

   orb_pingpong_buffer #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_AHEAD(1),
      .REPEAT_ON_UNDERRUN(1), .CNT_W(CNT_W)
   ) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a.slave)
   );

   orb_pingpong_buffer #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .READ_AHEAD(1),
      .REPEAT_ON_UNDERRUN(0), .CNT_W(CNT_W)
   ) dut_b (
      .clk(clk), .rst(rst), .bus(bus_b.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle_a();
      bus_a.wr_en   = 1'b0;
      bus_a.wr_addr = '0;
      bus_a.wr_data = '0;
      bus_a.wr_done = 1'b0;
      bus_a.rd_en   = 1'b0;
      bus_a.rd_addr = '0;
      bus_a.swap    = 1'b0;
   endtask

   task automatic write_a(input int addr, input int data);
      bus_a.wr_en   = 1'b1;
      bus_a.wr_addr = ADDR_W'(addr);
      bus_a.wr_data = DATA_W'(data);
      cyc();
      bus_a.wr_en   = 1'b0;
   endtask

   task automatic read_a(input string tag, input int addr, input int exp);
      bus_a.rd_en   = 1'b1;
      bus_a.rd_addr = ADDR_W'(addr);
      cyc();
      bus_a.rd_en   = 1'b0;
      check(tag, 32'(bus_a.rd_data), 32'(exp));
      check({tag, "_valid"}, 32'(bus_a.rd_valid), 32'd1);
   endtask

   initial begin
      n_cmp = 0;
      n_err = 0;
      idle_a();
      bus_b.wr_en = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
      bus_b.wr_done = 1'b0; bus_b.rd_en = 1'b0; bus_b.rd_addr = '0;
      bus_b.swap = 1'b0;

      // Reset with a swap request that must be ignored.
      rst = 1'b1;
      bus_a.swap = 1'b1;
      repeat (2) cyc();
      rst = 1'b0;
      bus_a.swap = 1'b0;
      check("rst_bank_rd",  32'(bus_a.bank_rd), 32'd0);
      check("rst_frame_rd", 32'(bus_a.frame_ready), 32'd0);
      check("rst_rd_data",  32'(bus_a.rd_data), 32'd0);
      check("rst_rd_valid", 32'(bus_a.rd_valid), 32'd0);
      check("rst_underrun", 32'(bus_a.underrun_cnt), 32'd0);
      check("rst_drop",     32'(bus_a.drop_cnt), 32'd0);

      // Legacy blind swap: three back-to-back underruns toggle the bank.
      bus_b.swap = 1'b1;
      cyc();
      check("blind_bank1", 32'(bus_b.bank_rd), 32'd1);
      cyc();
      check("blind_bank2", 32'(bus_b.bank_rd), 32'd0);
      cyc();
      bus_b.swap = 1'b0;
      check("blind_bank3", 32'(bus_b.bank_rd), 32'd1);
      check("blind_und",   32'(bus_b.underrun_cnt), 32'd3);
      check("blind_frdy",  32'(bus_b.frame_ready), 32'd0);

      // Fill bank 1, declare the frame, swap to it.
      for (int i = 0; i < 16; i++) write_a(i, 32'h100 + i);
      bus_a.wr_done = 1'b1;
      cyc();
      bus_a.wr_done = 1'b0;
      check("fill_frdy", 32'(bus_a.frame_ready), 32'd1);
      check("fill_bank", 32'(bus_a.bank_rd), 32'd0);
      bus_a.swap = 1'b1;
      cyc();
      bus_a.swap = 1'b0;
      check("swap_bank", 32'(bus_a.bank_rd), 32'd1);
      check("swap_frdy", 32'(bus_a.frame_ready), 32'd0);
      check("swap_und",  32'(bus_a.underrun_cnt), 32'd0);

      // Streamed reads at rd_addr=i-1; i=0 uses 2047, which wraps to 0.
      for (int i = 0; i < 16; i++) begin
         bus_a.rd_en   = 1'b1;
         bus_a.rd_addr = ADDR_W'(i - 1);
         cyc();
         check($sformatf("rd_%0d", i), 32'(bus_a.rd_data), 32'h100 + i);
         check($sformatf("rd_valid_%0d", i), 32'(bus_a.rd_valid), 32'd1);
      end
      bus_a.rd_en = 1'b0;
      cyc();
      check("rd_idle_valid", 32'(bus_a.rd_valid), 32'd0);
      check("rd_idle_hold",  32'(bus_a.rd_data), 32'h10F);

      // Underrun with repeat: bank holds, old frame still readable.
      bus_a.swap = 1'b1;
      repeat (3) cyc();
      bus_a.swap = 1'b0;
      check("und_bank", 32'(bus_a.bank_rd), 32'd1);
      check("und_cnt",  32'(bus_a.underrun_cnt), 32'd3);
      check("und_frdy", 32'(bus_a.frame_ready), 32'd0);
      read_a("und_rd", 4, 32'h105);

      // Drop: two completions with no swap between.
      for (int i = 0; i < 4; i++) write_a(i, 32'h200 + i);
      bus_a.wr_done = 1'b1;
      cyc();
      cyc();
      bus_a.wr_done = 1'b0;
      check("drop_cnt",  32'(bus_a.drop_cnt), 32'd1);
      check("drop_frdy", 32'(bus_a.frame_ready), 32'd1);
      bus_a.swap = 1'b1;
      cyc();
      bus_a.swap = 1'b0;
      check("drop_bank",  32'(bus_a.bank_rd), 32'd0);
      check("drop_frdy2", 32'(bus_a.frame_ready), 32'd0);
      check("drop_cnt2",  32'(bus_a.drop_cnt), 32'd1);
      read_a("drop_rd", 1, 32'h202);

      // Swap + wr_done together with no frame waiting; read in that cycle
      // sees the old bank.
      for (int i = 0; i < 4; i++) write_a(i, 32'h300 + i);
      bus_a.swap = 1'b1; bus_a.wr_done = 1'b1;
      bus_a.rd_en = 1'b1; bus_a.rd_addr = ADDR_W'(0);
      cyc();
      idle_a();
      check("sim0_bank", 32'(bus_a.bank_rd), 32'd1);
      check("sim0_frdy", 32'(bus_a.frame_ready), 32'd0);
      check("sim0_und",  32'(bus_a.underrun_cnt), 32'd3);
      check("sim0_drop", 32'(bus_a.drop_cnt), 32'd1);
      check("sim0_old",  32'(bus_a.rd_data), 32'h201);
      read_a("sim0_new", 0, 32'h301);

      // Swap + wr_done with a frame waiting; wr_en in that cycle lands in
      // the old inactive bank (bank 0), rd_en reads the old bank (bank 1).
      bus_a.wr_done = 1'b1;
      cyc();
      bus_a.wr_done = 1'b0;
      check("sim1_frdy_pre", 32'(bus_a.frame_ready), 32'd1);
      bus_a.swap = 1'b1; bus_a.wr_done = 1'b1;
      bus_a.wr_en = 1'b1; bus_a.wr_addr = ADDR_W'(5); bus_a.wr_data = DATA_W'(32'h3AA);
      bus_a.rd_en = 1'b1; bus_a.rd_addr = ADDR_W'(2);
      cyc();
      idle_a();
      check("sim1_bank", 32'(bus_a.bank_rd), 32'd0);
      check("sim1_frdy", 32'(bus_a.frame_ready), 32'd0);
      check("sim1_drop", 32'(bus_a.drop_cnt), 32'd2);
      check("sim1_old",  32'(bus_a.rd_data), 32'h303);
      read_a("sim1_wr", 4, 32'h3AA);

      // Saturation: 300 more underruns.
      bus_a.swap = 1'b1;
      repeat (300) cyc();
      bus_a.swap = 1'b0;
      check("sat_und",  32'(bus_a.underrun_cnt), 32'd255);
      check("sat_bank", 32'(bus_a.bank_rd), 32'd0);

      // Build frame_ready=1 with bank_rd=1, then reset mid-operation.
      bus_a.wr_done = 1'b1;
      cyc();
      bus_a.wr_done = 1'b0;
      bus_a.swap = 1'b1;
      cyc();
      bus_a.swap = 1'b0;
      bus_a.wr_done = 1'b1;
      cyc();
      bus_a.wr_done = 1'b0;
      check("pre_rst_bank", 32'(bus_a.bank_rd), 32'd1);
      check("pre_rst_frdy", 32'(bus_a.frame_ready), 32'd1);
      read_a("pre_rst_rd", 0, 32'h301);
      rst = 1'b1;
      bus_a.swap = 1'b1; bus_a.wr_done = 1'b1; bus_a.rd_en = 1'b1;
      cyc();
      check("mrst_bank",  32'(bus_a.bank_rd), 32'd0);
      check("mrst_frdy",  32'(bus_a.frame_ready), 32'd0);
      check("mrst_data",  32'(bus_a.rd_data), 32'd0);
      check("mrst_valid", 32'(bus_a.rd_valid), 32'd0);
      check("mrst_und",   32'(bus_a.underrun_cnt), 32'd0);
      check("mrst_drop",  32'(bus_a.drop_cnt), 32'd0);
      rst = 1'b0;
      idle_a();
      cyc();
      check("post_rst_bank", 32'(bus_a.bank_rd), 32'd0);
      check("post_rst_frdy", 32'(bus_a.frame_ready), 32'd0);
      check("post_rst_und",  32'(bus_a.underrun_cnt), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/orb_pingpong_buffer.md
# orb_pingpong_buffer

Parametrised double-buffered (ping-pong) frame store between the LCB receive path (UART_RX → OrbPacker) and the orbit-frame serialiser (M16), in a single clock domain. The writer fills the inactive bank while the reader streams the active bank. At each reader frame boundary the banks swap, but only if the writer has declared a complete frame. Otherwise the block repeats the old frame and counts an underrun. Writer overruns are counted as drops, and word width, bank depth, read-ahead and swap mode are generics.

## Interface
Parameters:
- DATA_W, 12, orbit word width
- ADDR_W, 11, bank address width; each bank holds 2**ADDR_W words
- READ_AHEAD, 1, constant added to rd_addr before RAM access (modulo 2**ADDR_W)
- REPEAT_ON_UNDERRUN, 1, 1 = keep current bank when no frame ready; 0 = toggle on every swap (legacy blind swap)
- CNT_W, 8, width of saturating status counters

Ports:
- clk  in  1  system clock (80 MHz domain); all logic on rising edge
- rst  in  1  synchronous, active-high reset
- wr_en  in  1  write strobe, one word per cycle
- wr_addr  in  ADDR_W  write address within inactive bank
- wr_data  in  DATA_W  word to write
- wr_done  in  1  one-cycle pulse: writer finished a frame in inactive bank
- rd_en  in  1  read strobe
- rd_addr  in  ADDR_W  reader address, before READ_AHEAD offset
- rd_data  out  DATA_W  registered read word
- rd_valid  out  1  high one cycle after an accepted rd_en
- swap  in  1  one-cycle pulse at reader frame boundary
- bank_rd  out  1  bank currently read (0/1); writer targets ~bank_rd
- frame_ready  out  1  complete frame waiting in inactive bank
- underrun_cnt  out  CNT_W  swaps with no ready frame, saturating
- drop_cnt  out  CNT_W  frames overwritten before being read, saturating

## Operation
- Storage: two banks, each 2**ADDR_W × DATA_W, one write port and one registered read port. Contents are not reset.
- Write: when wr_en=1, wr_data goes to bank ~bank_rd at wr_addr. The active bank is never written.
- Read: when rd_en=1, bank bank_rd is read at (rd_addr + READ_AHEAD) mod 2**ADDR_W. rd_data is updated on the next edge and otherwise holds its value. rd_valid mirrors rd_en delayed by one cycle.
- Bank state machine. States: RD0 (bank_rd=0) and RD1 (bank_rd=1), each qualified by the frame_ready flag.
  - wr_done, no swap: if frame_ready=0, set frame_ready=1. If frame_ready=1, frame_ready stays 1 and drop_cnt++.
  - swap, no wr_done:
    - frame_ready=1: toggle bank_rd and clear frame_ready.
    - frame_ready=0 with REPEAT_ON_UNDERRUN=1: bank_rd is unchanged and underrun_cnt++.
    - frame_ready=0 with REPEAT_ON_UNDERRUN=0: toggle bank_rd and underrun_cnt++.
  - swap and wr_done in the same cycle, frame_ready=0: treated as ready. Toggle bank_rd, frame_ready stays 0, no counter change.
  - swap and wr_done in the same cycle, frame_ready=1: toggle bank_rd, frame_ready=0, drop_cnt++.
- Counters saturate at 2**CNT_W−1 and never wrap.

## Timing
- Reset values: bank_rd=0, frame_ready=0, rd_data=0, rd_valid=0, underrun_cnt=0, drop_cnt=0.
- During reset, wr_en, rd_en, swap and wr_done are ignored. Asserting rst mid-frame discards pending state on the next edge.
- Read latency is 1 clock from rd_en to rd_data/rd_valid.
- Swap-cycle rules:
  - bank_rd, frame_ready and the counters update on the edge ending the swap/wr_done cycle.
  - A rd_en in the swap cycle reads the old bank.
  - A wr_en in the swap cycle writes the old inactive bank.
  - The new bank takes effect from the next cycle.
- Read/write collision cannot occur, because the two ports always address different banks.
- Address wrap: rd_addr=2**ADDR_W−1 with READ_AHEAD=1 reads address 0.
- Back-to-back swaps are legal; each is evaluated independently.

## Test plan
- Reset and basic read: write 0x100+i at i=0..15 to bank 1, pulse wr_done, then swap. Expect bank_rd=1 and frame_ready=0. Then rd_en with rd_addr=i−1 returns 0x100+i one cycle later, with rd_valid=1.
- Underrun: with REPEAT_ON_UNDERRUN=1 and no wr_done, pulse swap 3 times. Expect bank_rd unchanged, underrun_cnt=3, and reads returning the old frame data. Rerun with REPEAT_ON_UNDERRUN=0: bank_rd toggles 3 times and underrun_cnt=3.
- Drop: pulse wr_done twice with no swap between, then swap. Expect drop_cnt=1, then bank_rd toggled and frame_ready=0.
- Simultaneous events:
  - swap and wr_done in the same cycle with frame_ready=0: bank toggles, no counter change.
  - Same with frame_ready=1: bank toggles, drop_cnt++, frame_ready=0.
  - rd_en in the swap cycle returns old-bank data.
- Saturation and wrap:
  - Force 300 underruns with CNT_W=8: underrun_cnt=255.
  - rd_addr=2047 with READ_AHEAD=1 returns the word at address 0.
- Mid-operation reset: assert rst for 1 cycle while frame_ready=1 and bank_rd=1. Expect all outputs 0 on the next cycle, and a swap pulsed during reset has no effect.
